// File: rtl/ddr_pkg.sv
// Shared DDR constants and arbiter encodings.
// Used by the request arbiter, its refresh timer and the DDR core.
package ddr_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 32;

  // tREFI is 7.8 us; at 133 MHz that is about 1037 cycles, so 1000 leaves margin.
  localparam int CLK_MHZ              = 133;
  localparam int TREFI_NS             = 7800;
  localparam int REFRESH_INTERVAL_DEF = 1000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_READ = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ddr_request_arbiter_if.sv
// Requester and DDR command/read-return signals of the request arbiter.
// slave = arbiter side, master = requesters plus DDR core side.
interface ddr_request_arbiter_if
  import ddr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;

  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt;

  logic              mem_cmd_valid;
  logic              mem_cmd_write;
  logic              mem_cmd_refresh;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_wdata;
  logic              mem_cmd_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, draw_req, draw_addr, draw_wdata,
           mem_cmd_ready, mem_rvalid, mem_rdata,
    output disp_gnt, disp_rdata, disp_rvalid, draw_gnt,
           mem_cmd_valid, mem_cmd_write, mem_cmd_refresh, mem_cmd_addr, mem_cmd_wdata
  );

  modport master (
    output disp_req, disp_addr, draw_req, draw_addr, draw_wdata,
           mem_cmd_ready, mem_rvalid, mem_rdata,
    input  disp_gnt, disp_rdata, disp_rvalid, draw_gnt,
           mem_cmd_valid, mem_cmd_write, mem_cmd_refresh, mem_cmd_addr, mem_cmd_wdata
  );
endinterface

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval counter with pending flag and sticky missed flag.
// A wrap coinciding with the clear starts a new interval rather than a miss.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF
) (
  input  logic clk133_p,
  input  logic rst,
  input  logic refresh_clr,
  output logic refresh_pending,
  output logic refresh_missed
);
  localparam int CNT_W = $clog2(REFRESH_INTERVAL);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pending_reg, pending_next;
  logic             missed_reg, missed_next;
  logic             wrap;

  always_comb begin
    wrap         = (cnt_reg == CNT_W'(REFRESH_INTERVAL - 1));
    cnt_next     = wrap ? '0 : cnt_reg + CNT_W'(1);
    pending_next = pending_reg;
    missed_next  = missed_reg;
    if (wrap) begin
      pending_next = 1'b1;
      if (pending_reg && !refresh_clr) missed_next = 1'b1;
    end else if (refresh_clr) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      missed_reg  <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      missed_reg  <= missed_next;
    end
  end

  assign refresh_pending = pending_reg;
  assign refresh_missed  = missed_reg;
endmodule

// File: rtl/ddr_request_arbiter.sv
// Arbitrates display reads, draw writes and auto-refresh onto one DDR command port.
// Draw gets priority once display has been granted STARVE_LIMIT times while draw waited.
module ddr_request_arbiter
  import ddr_pkg::*;
#(
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int DATA_W           = DATA_W_DEF,
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int STARVE_LIMIT     = 8
) (
  input  logic                  clk133_p,
  input  logic                  rst,
  ddr_request_arbiter_if.slave  bus,
  output logic                  refresh_missed
);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state_reg, state_next;
  logic              valid_reg, valid_next;
  logic              write_reg, write_next;
  logic              refresh_reg, refresh_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              disp_gnt_reg, disp_gnt_next;
  logic              draw_gnt_reg, draw_gnt_next;
  logic              rvalid_reg, rvalid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [STV_W-1:0]  starve_reg, starve_next;
  logic              refresh_pending;
  logic              refresh_clr;
  logic              draw_starved;

  ddr_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_refresh (
    .clk133_p        (clk133_p),
    .rst             (rst),
    .refresh_clr     (refresh_clr),
    .refresh_pending (refresh_pending),
    .refresh_missed  (refresh_missed)
  );

  always_comb begin
    state_next    = state_reg;
    valid_next    = valid_reg;
    write_next    = write_reg;
    refresh_next  = refresh_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    disp_gnt_next = 1'b0;
    draw_gnt_next = 1'b0;
    rvalid_next   = 1'b0;
    rdata_next    = rdata_reg;
    starve_next   = starve_reg;
    refresh_clr   = 1'b0;
    draw_starved  = (starve_reg == STV_W'(STARVE_LIMIT));

    case (state_reg)
      ST_IDLE: begin
        if (refresh_pending) begin
          state_next   = ST_ISSUE;
          valid_next   = 1'b1;
          write_next   = 1'b0;
          refresh_next = 1'b1;
          addr_next    = '0;
          wdata_next   = '0;
        end else if (bus.draw_req && (draw_starved || !bus.disp_req)) begin
          state_next    = ST_ISSUE;
          valid_next    = 1'b1;
          write_next    = 1'b1;
          refresh_next  = 1'b0;
          addr_next     = bus.draw_addr;
          wdata_next    = bus.draw_wdata;
          draw_gnt_next = 1'b1;
          starve_next   = '0;
        end else if (bus.disp_req) begin
          state_next    = ST_ISSUE;
          valid_next    = 1'b1;
          write_next    = 1'b0;
          refresh_next  = 1'b0;
          addr_next     = bus.disp_addr;
          wdata_next    = '0;
          disp_gnt_next = 1'b1;
          if (bus.draw_req && !draw_starved) starve_next = starve_reg + STV_W'(1);
        end
      end
      ST_ISSUE: begin
        if (bus.mem_cmd_ready) begin
          valid_next  = 1'b0;
          refresh_clr = refresh_reg;
          state_next  = (refresh_reg || write_reg) ? ST_IDLE : ST_WAIT_READ;
        end
      end
      ST_WAIT_READ: begin
        if (bus.mem_rvalid) begin
          rdata_next  = bus.mem_rdata;
          rvalid_next = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      valid_reg    <= 1'b0;
      write_reg    <= 1'b0;
      refresh_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      disp_gnt_reg <= 1'b0;
      draw_gnt_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      starve_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      valid_reg    <= valid_next;
      write_reg    <= write_next;
      refresh_reg  <= refresh_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      disp_gnt_reg <= disp_gnt_next;
      draw_gnt_reg <= draw_gnt_next;
      rvalid_reg   <= rvalid_next;
      rdata_reg    <= rdata_next;
      starve_reg   <= starve_next;
    end
  end

  assign bus.mem_cmd_valid   = valid_reg;
  assign bus.mem_cmd_write   = write_reg;
  assign bus.mem_cmd_refresh = refresh_reg;
  assign bus.mem_cmd_addr    = addr_reg;
  assign bus.mem_cmd_wdata   = wdata_reg;
  assign bus.disp_gnt        = disp_gnt_reg;
  assign bus.draw_gnt        = draw_gnt_reg;
  assign bus.disp_rvalid     = rvalid_reg;
  assign bus.disp_rdata      = rdata_reg;
endmodule

// File: doc/ddr_request_arbiter.md
Name: ddr_request_arbiter

Overview:
- Shares the single DDR command port between the display read fetcher and the draw writer, and schedules periodic auto-refresh.
- Sits between the VGA pixel fetch / graphics draw logic and the DDR command/sequencer core.
- Issues one command at a time over a valid/ready handshake and routes read data back to the display requester.
- Prevents the draw path from starving under continuous display demand.

Parameters:
ADDR_W, 24, width of the linear DDR word address (bank/row/column split done downstream)
DATA_W, 32, data word width (matches the 32-bit DDR word)
REFRESH_INTERVAL, 1000, clk133_p cycles between refresh requests (below 7.8 us tREFI at 133 MHz)
STARVE_LIMIT, 8, consecutive display grants while draw waits before draw gets priority over display

Ports:
clk133_p  in  1  system clock, 133 MHz; all logic on the rising edge
rst  in  1  asynchronous reset, active-high
disp_req  in  1  display read request; held with disp_addr until disp_gnt
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  one-cycle pulse: display request latched
disp_rdata  out  DATA_W  returned read word
disp_rvalid  out  1  one-cycle pulse: disp_rdata valid
draw_req  in  1  draw write request; held with draw_addr/draw_wdata until draw_gnt
draw_addr  in  ADDR_W  draw write address
draw_wdata  in  DATA_W  draw write data
draw_gnt  out  1  one-cycle pulse: draw request latched
mem_cmd_valid  out  1  command presented to DDR core
mem_cmd_write  out  1  1 = write, 0 = read (ignored when mem_cmd_refresh = 1)
mem_cmd_refresh  out  1  command is auto-refresh
mem_cmd_addr  out  ADDR_W  command address
mem_cmd_wdata  out  DATA_W  write data
mem_cmd_ready  in  1  DDR core accepts the command this cycle
mem_rvalid  in  1  read word available from DDR core
mem_rdata  in  DATA_W  read word
refresh_missed  out  1  sticky: a refresh interval expired while a refresh was still pending

Behaviour:
- Reset (async, any time, including mid-command or mid-read):
  - All outputs 0; state IDLE.
  - Refresh counter, starvation counter and refresh_pending cleared.
  - Any in-flight command is abandoned.
- Refresh counter:
  - Increments every cycle.
  - At REFRESH_INTERVAL-1 it wraps to 0 and sets refresh_pending.
  - If refresh_pending is already set at wrap, refresh_missed is set (sticky until rst).
  - refresh_pending clears on the handshake of the refresh command.
- State IDLE: arbitrate each cycle. Priority:
  1. refresh_pending
  2. draw_req, if starve_cnt == STARVE_LIMIT
  3. disp_req
  4. draw_req
  No request pending: stay IDLE.
- Grant (decision in cycle N, state ISSUE in cycle N+1):
  - Command registers load in cycle N+1: mem_cmd_valid=1, with addr/wdata/write/refresh.
  - The matching gnt pulses high for exactly cycle N+1. Refresh has no gnt.
  - Requesters may change req/addr/data from cycle N+2; inputs are not sampled outside IDLE.
- ISSUE: hold all mem_cmd_* stable until mem_cmd_valid && mem_cmd_ready. On that cycle's edge:
  - mem_cmd_valid drops.
  - Read: go to WAIT_READ.
  - Write or refresh: go to IDLE; the next grant is decided the following cycle, so minimum spacing is 2 cycles.
- WAIT_READ:
  - Only one read outstanding.
  - On mem_rvalid, register mem_rdata into disp_rdata and pulse disp_rvalid the next cycle; state returns to IDLE the same edge.
  - disp_rdata holds its value until the next return.
  - mem_rvalid outside WAIT_READ is ignored.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) when display is granted while draw_req = 1.
  - Cleared when draw is granted.
  - Unchanged on refresh grants.
- Simultaneous events:
  - Refresh wrap in the same cycle refresh_pending clears: pending stays set (new interval); refresh_missed is not set.
  - disp_req and draw_req both high with starve_cnt < STARVE_LIMIT: display wins.

Decomposition:
- Shared package ddr_pkg:
  - state encoding (IDLE, ISSUE, WAIT_READ)
  - ADDR_W/DATA_W defaults
  - tREFI-derived REFRESH_INTERVAL constant, also used by the DDR core
- One natural sub-module, ddr_refresh_timer: counter, refresh_pending, refresh_missed, with a clear input driven by the arbiter.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset: assert rst mid-ISSUE with mem_cmd_valid=1 -> next sample all outputs 0; after release, first refresh_pending exactly REFRESH_INTERVAL cycles later.
- Single read: disp_req=1, disp_addr=0x000100, mem_cmd_ready=1 immediately, mem_rvalid 5 cycles later with 0xAAAA5555:
  - disp_gnt pulses once.
  - mem_cmd_write=0, mem_cmd_addr=0x000100.
  - disp_rvalid pulses with disp_rdata=0xAAAA5555.
- Backpressure: draw write addr 0x00ABCD, data 0x12345678, mem_cmd_ready low 10 cycles -> mem_cmd_* stable all 10 cycles; draw_gnt single pulse; IDLE after the handshake.
- Starvation: disp_req and draw_req held high continuously -> exactly 8 display grants, then 1 draw grant, then the pattern repeats.
- Refresh priority: refresh_pending and disp_req in the same IDLE cycle -> mem_cmd_refresh=1 issued first, display granted after the refresh handshake.
- Missed refresh: hold mem_cmd_ready=0 for more than REFRESH_INTERVAL cycles with a refresh pending -> refresh_missed goes 1 and stays 1 until rst.
